// File: rtl/codigo_2de5_pkg.sv
// Shared definitions for the 2-of-5 coded 7-segment scan controller.
// Contents: scan state encoding, coded digit width, blank/dash segment patterns.
`timescale 1ns/1ps
package codigo_2de5_pkg;

  // Width of one 2-of-5 coded digit (E1..E5).
  localparam int unsigned CODE_W = 5;

  // Segment patterns, [6]=A ... [0]=G, active-high.
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

endpackage

// File: rtl/codigo_2de5_valid.sv
// Combinational 2-of-5 code check.
// Ports:
//   code  - 5-bit coded digit, [4]=E1 ... [0]=E5
//   valid - 1 when exactly two bits of code are set
`timescale 1ns/1ps
module codigo_2de5_valid
  import codigo_2de5_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              valid
);

  logic [2:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < int'(CODE_W); i++) begin
      ones = ones + {2'b00, code[i]};
    end
    valid = (ones == 3'd2);
  end

endmodule

// File: rtl/codigo_2de5_scan_ctrl.sv
// Time-multiplexing controller for an N-digit 7-segment display fed by 2-of-5
// coded digits. One code at a time is sent to a shared external decoder; the
// decoded segments come back on seg_in and are driven out with a one-hot digit
// select, separated by dark blanking slots.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - scan enable (0 = dark)
//   load       - one-cycle strobe capturing code_in into the shadow register
//   code_in    - digit k at [5k+4:5k], bit 5k+4 = E1
//   dec_e      - code presented to the shared decoder
//   seg_in     - decoder result, [6]=A ... [0]=G
//   seg_out    - segments to display
//   dig_sel    - one-hot digit enable
//   err        - per-digit "stored code is not 2-of-5"
//   loaded     - at least one load since reset
`timescale 1ns/1ps
module codigo_2de5_scan_ctrl
  import codigo_2de5_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         load,
  input  logic [CODE_W*N_DIGITS-1:0]   code_in,
  output logic [CODE_W-1:0]            dec_e,
  input  logic [6:0]                   seg_in,
  output logic [6:0]                   seg_out,
  output logic [N_DIGITS-1:0]          dig_sel,
  output logic [N_DIGITS-1:0]          err,
  output logic                         loaded
);

  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  scan_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CODE_W*N_DIGITS-1:0]  shadow_q, shadow_d;
  logic [N_DIGITS-1:0]         err_q, err_d;
  logic                        loaded_q, loaded_d;
  logic [CODE_W-1:0]           dec_e_q, dec_e_d;
  logic                        slot_ok_q, slot_ok_d;
  logic [6:0]                  seg_out_q, seg_out_d;
  logic [N_DIGITS-1:0]         dig_sel_q, dig_sel_d;
  logic                        enter_blank;
  logic                        lit;

  logic [CODE_W-1:0]           digit_code [N_DIGITS];
  logic [N_DIGITS-1:0]         in_valid;

  for (genvar k = 0; k < int'(N_DIGITS); k++) begin : g_digit
    assign digit_code[k] = shadow_q[CODE_W*k +: CODE_W];

    codigo_2de5_valid u_valid (
      .code  (code_in[CODE_W*k +: CODE_W]),
      .valid (in_valid[k])
    );
  end

  // Scan sequencing: dwell counter counts cycles spent in the current state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    enter_blank = 1'b0;
    if (!en) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StBlank;
          idx_d       = '0;
          cnt_d       = '0;
          enter_blank = 1'b1;
        end
        StBlank: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StShow: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            state_d     = StBlank;
            cnt_d       = '0;
            idx_d       = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            enter_blank = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered outputs, one cycle behind the state. Gated by en so the display
  // goes dark on the edge that sees en low.
  always_comb begin
    lit       = en && loaded_q && (state_q == StShow);
    dig_sel_d = '0;
    seg_out_d = SEG_OFF;
    if (lit) begin
      dig_sel_d[idx_q] = 1'b1;
      seg_out_d        = slot_ok_q ? seg_in : SEG_DASH;
    end

    // The slot's code and status are frozen at blank entry so a load mid-slot
    // cannot change the digit being shown.
    dec_e_d   = dec_e_q;
    slot_ok_d = slot_ok_q;
    if (enter_blank) begin
      dec_e_d   = digit_code[idx_d];
      slot_ok_d = loaded_q & ~err_q[idx_d];
    end

    shadow_d = shadow_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    if (load) begin
      shadow_d = code_in;
      err_d    = ~in_valid;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      err_q     <= '0;
      loaded_q  <= 1'b0;
      dec_e_q   <= '0;
      slot_ok_q <= 1'b0;
      seg_out_q <= SEG_OFF;
      dig_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      err_q     <= err_d;
      loaded_q  <= loaded_d;
      dec_e_q   <= dec_e_d;
      slot_ok_q <= slot_ok_d;
      seg_out_q <= seg_out_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign dec_e   = dec_e_q;
  assign seg_out = seg_out_q;
  assign dig_sel = dig_sel_q;
  assign err     = err_q;
  assign loaded  = loaded_q;

endmodule
